// File: rtl/trace_mem_ctrl_pkg.sv
// Shared constants and state encodings for the trace memory controller.
package trace_mem_ctrl_pkg;

  localparam int TRB_WIDTH      = 32;
  localparam int TRB_DEPTH      = 64;
  localparam int TRB_DELAY_BITS = 16;

  // Capture side: armed until trigger, counting post-trigger words, then frozen.
  typedef enum logic [1:0] {
    T_ARMED  = 2'd0,
    T_POST   = 2'd1,
    T_FROZEN = 2'd2
  } trace_state_t;

  // Replay side: idle, waiting for the host to supply a word, reading the RAM.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2
  } stream_state_t;

  typedef enum logic {
    MODE_TRACE  = 1'b0,
    MODE_STREAM = 1'b1
  } mode_t;

endpackage

// File: rtl/trace_mem_ctrl_if.sv
// Tracer/host-facing signal bundle of the trace memory controller.
// Names carry the controller's point of view (_i into it, _o out of it).
interface trace_mem_ctrl_if #(
  parameter int W     = 32,
  parameter int DEPTH = 64,
  parameter int DB    = 16
) ();
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(W);
  localparam int FW = AW + 1;

  logic          en_i;
  logic          mode_i;
  logic [DB-1:0] trg_delay_i;
  logic          store_i;
  logic [W-1:0]  data_i;
  logic [PW-1:0] event_pos_i;
  logic          trg_event_i;
  logic          req_i;
  logic          host_we_i;
  logic [W-1:0]  host_data_i;

  logic [W-1:0]  data_o;
  logic          load_o;
  logic          trg_event_o;
  logic [AW-1:0] trg_addr_o;
  logic [PW-1:0] trg_pos_o;
  logic [AW-1:0] wr_ptr_o;
  logic [FW-1:0] fill_o;
  logic          host_full_o;

  // Controller side.
  modport slave (
    input  en_i, mode_i, trg_delay_i, store_i, data_i, event_pos_i,
           trg_event_i, req_i, host_we_i, host_data_i,
    output data_o, load_o, trg_event_o, trg_addr_o, trg_pos_o,
           wr_ptr_o, fill_o, host_full_o
  );

  // Tracer/host side.
  modport master (
    output en_i, mode_i, trg_delay_i, store_i, data_i, event_pos_i,
           trg_event_i, req_i, host_we_i, host_data_i,
    input  data_o, load_o, trg_event_o, trg_addr_o, trg_pos_o,
           wr_ptr_o, fill_o, host_full_o
  );
endinterface

// File: rtl/trace_mem_ctrl_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with
// one cycle of latency. Read data only changes when a read is issued.
module trb_sdp_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Write and registered read share the clock; no reset so it maps onto block RAM.
  // NOTE: storage arrays are deliberately not reset; a reset port would prevent
  // RAM inference and the contents are always written before they are read.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/trace_mem_ctrl.sv
// Memory-side partner of the tracer: a trigger-aware ring buffer in trace
// mode, a host-filled FIFO replayed on request in stream mode.
module trace_mem_ctrl
  import trace_mem_ctrl_pkg::*;
#(
  parameter int W     = TRB_WIDTH,
  parameter int DEPTH = TRB_DEPTH,
  parameter int DB    = TRB_DELAY_BITS
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  trace_mem_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(W);
  localparam int FW = AW + 1;

  trace_state_t  t_state_q, t_state_d;
  stream_state_t s_state_q, s_state_d;
  logic          mode_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [DB-1:0] dly_q, dly_d;
  logic [AW-1:0] trg_addr_q, trg_addr_d;
  logic [PW-1:0] trg_pos_q, trg_pos_d;
  logic          trg_evt_q, trg_evt_d;
  logic          load_q, load_d;
  logic [W-1:0]  data_q, data_d;

  logic          mode_chg;
  logic          host_full;
  logic          wr_acc;
  logic          rd_done;
  logic          ram_we;
  logic [W-1:0]  ram_wdata;
  logic          ram_re;
  logic [W-1:0]  ram_rdata;

  assign mode_chg  = (bus.mode_i != mode_q);
  assign host_full = (fill_q == FW'(DEPTH));

  trb_sdp_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // State register for both FSMs and all datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_state_q  <= T_ARMED;
      s_state_q  <= S_IDLE;
      mode_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      dly_q      <= '0;
      trg_addr_q <= '0;
      trg_pos_q  <= '0;
      trg_evt_q  <= 1'b0;
      load_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      t_state_q  <= t_state_d;
      s_state_q  <= s_state_d;
      mode_q     <= bus.mode_i;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      dly_q      <= dly_d;
      trg_addr_q <= trg_addr_d;
      trg_pos_q  <= trg_pos_d;
      trg_evt_q  <= trg_evt_d;
      load_q     <= load_d;
      data_q     <= data_d;
    end
  end

  // Next-state logic for the trace and stream FSMs plus write-port mux.
  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    t_state_d  = t_state_q;
    s_state_d  = s_state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    dly_d      = dly_q;
    trg_addr_d = trg_addr_q;
    trg_pos_d  = trg_pos_q;
    trg_evt_d  = trg_evt_q;
    load_d     = 1'b0;
    data_d     = data_q;
    wr_acc     = 1'b0;
    rd_done    = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_wdata  = (bus.mode_i == MODE_STREAM) ? bus.host_data_i : bus.data_i;

    if (mode_chg) begin
      // Switching personality restarts both sides; RAM contents are kept.
      t_state_d  = T_ARMED;
      s_state_d  = S_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      dly_d      = '0;
      trg_addr_d = '0;
      trg_pos_d  = '0;
      trg_evt_d  = 1'b0;
      data_d     = '0;
    end else if (bus.en_i) begin
      if (bus.mode_i == MODE_TRACE) begin
        trg_evt_d = (t_state_q == T_FROZEN);
        unique case (t_state_q)
          T_ARMED: begin
            if (bus.store_i) begin
              ram_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (bus.trg_event_i) begin
              // The trigger belongs to the word being written now, so the
              // pre-increment address is recorded.
              trg_addr_d = wr_ptr_q;
              trg_pos_d  = bus.event_pos_i;
              dly_d      = bus.trg_delay_i;
              t_state_d  = (bus.trg_delay_i == '0) ? T_FROZEN : T_POST;
            end
          end
          T_POST: begin
            if (bus.store_i) begin
              ram_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + AW'(1);
              dly_d    = dly_q - DB'(1);
              if (dly_q == DB'(1)) t_state_d = T_FROZEN;
            end
          end
          T_FROZEN: ;
          default: t_state_d = T_ARMED;
        endcase
      end else begin
        // Host fills the FIFO; a write into a full FIFO is dropped.
        wr_acc = bus.host_we_i && !host_full;
        if (wr_acc) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
        unique case (s_state_q)
          S_IDLE: begin
            if (bus.req_i) begin
              if (fill_q != '0) begin
                ram_re    = 1'b1;
                s_state_d = S_READ;
              end else begin
                s_state_d = S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (fill_q != '0) begin
              ram_re    = 1'b1;
              s_state_d = S_READ;
            end
          end
          S_READ: begin
            data_d    = ram_rdata;
            load_d    = 1'b1;
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_done   = 1'b1;
            s_state_d = S_IDLE;
          end
          default: s_state_d = S_IDLE;
        endcase
        unique case ({wr_acc, rd_done})
          2'b10:   fill_d = fill_q + FW'(1);
          2'b01:   fill_d = fill_q - FW'(1);
          default: fill_d = fill_q;
        endcase
      end
    end
  end

  assign bus.data_o      = data_q;
  assign bus.load_o      = load_q;
  assign bus.trg_event_o = trg_evt_q;
  assign bus.trg_addr_o  = trg_addr_q;
  assign bus.trg_pos_o   = trg_pos_q;
  assign bus.wr_ptr_o    = wr_ptr_q;
  assign bus.fill_o      = fill_q;
  assign bus.host_full_o = host_full;
endmodule
